wishbone_rr_arbiter: RTL and testbench

WISHBONE_RR_ARBITER -- requirements
Module: wishbone_rr_arbiter

---
 rtl/wishbone_rr_arbiter_if.sv | 51 +++++
 rtl/wishbone_rr_arbiter.sv | 124 ++++++++++++
 tb/tb_wishbone_rr_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wishbone_rr_arbiter_if.sv
// Bus bundle for the round-robin Wishbone arbiter: N master ports plus one slave port.
// slave modport is the arbiter's view; master modport is the surrounding system's view.
interface wishbone_rr_arbiter_if #(
   parameter int NUM_MASTERS = 2,
   parameter int ADDR_W      = 30,
   parameter int DATA_W      = 32
);
   localparam int SEL_W = DATA_W / 8;

   logic [NUM_MASTERS-1:0][ADDR_W-1:0] m_adr;
   logic [NUM_MASTERS-1:0][DATA_W-1:0] m_dat_w;
   logic [NUM_MASTERS-1:0][SEL_W-1:0]  m_sel;
   logic [NUM_MASTERS-1:0]             m_cyc;
   logic [NUM_MASTERS-1:0]             m_stb;
   logic [NUM_MASTERS-1:0]             m_we;
   logic [NUM_MASTERS-1:0][2:0]        m_cti;
   logic [NUM_MASTERS-1:0][1:0]        m_bte;
   logic [NUM_MASTERS-1:0][DATA_W-1:0] m_dat_r;
   logic [NUM_MASTERS-1:0]             m_ack;
   logic [NUM_MASTERS-1:0]             m_err;

   logic [ADDR_W-1:0] s_adr;
   logic [DATA_W-1:0] s_dat_w;
   logic [SEL_W-1:0]  s_sel;
   logic              s_cyc;
   logic              s_stb;
   logic              s_we;
   logic [2:0]        s_cti;
   logic [1:0]        s_bte;
   logic [DATA_W-1:0] s_dat_r;
   logic              s_ack;
   logic              s_err;

   logic [NUM_MASTERS-1:0] grant;

   modport slave (
      input  m_adr, m_dat_w, m_sel, m_cyc, m_stb, m_we, m_cti, m_bte,
      output m_dat_r, m_ack, m_err,
      output s_adr, s_dat_w, s_sel, s_cyc, s_stb, s_we, s_cti, s_bte,
      input  s_dat_r, s_ack, s_err,
      output grant
   );

   modport master (
      output m_adr, m_dat_w, m_sel, m_cyc, m_stb, m_we, m_cti, m_bte,
      input  m_dat_r, m_ack, m_err,
      input  s_adr, s_dat_w, s_sel, s_cyc, s_stb, s_we, s_cti, s_bte,
      output s_dat_r, s_ack, s_err,
      input  grant
   );
endinterface

// File: rtl/wishbone_rr_arbiter.sv
// Round-robin Wishbone classic arbiter, N masters onto one slave, one owner per m_cyc span.
// Optional stall watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wishbone_rr_arbiter #(
   parameter int NUM_MASTERS    = 2,
   parameter int ADDR_W         = 30,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   wishbone_rr_arbiter_if.slave  bus
);
   localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

   typedef enum logic {IDLE, OWNED} state_e;

   state_e                 state_q, state_d;
   logic [IDX_W-1:0]       owner_q, owner_d;
   logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
   logic [NUM_MASTERS-1:0] grant_q, grant_d;
   logic [IDX_W-1:0]       pick;
   logic                   pick_vld;
   logic                   owned;
   logic                   to_fire;

   function automatic logic [IDX_W-1:0] wrap(input int v);
      return (v >= NUM_MASTERS) ? IDX_W'(v - NUM_MASTERS) : IDX_W'(v);
   endfunction

   assign owned = (state_q == OWNED);

   // Scan from the farthest offset down so the requester closest to rr_ptr wins.
   always_comb begin
      pick     = '0;
      pick_vld = 1'b0;
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
         if (bus.m_cyc[wrap(int'(rr_ptr_q) + i)]) begin
            pick     = wrap(int'(rr_ptr_q) + i);
            pick_vld = 1'b1;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      rr_ptr_d = rr_ptr_q;
      grant_d  = grant_q;
      case (state_q)
         IDLE: begin
            if (pick_vld) begin
               state_d  = OWNED;
               owner_d  = pick;
               rr_ptr_d = wrap(int'(pick) + 1);
               grant_d  = NUM_MASTERS'(1) << pick;
            end
         end
         OWNED: begin
            // Release always passes through IDLE, guaranteeing a gap between owners.
            if (!bus.m_cyc[owner_q]) begin
               state_d = IDLE;
               grant_d = '0;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         owner_q  <= '0;
         rr_ptr_q <= '0;
         grant_q  <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         rr_ptr_q <= rr_ptr_d;
         grant_q  <= grant_d;
      end
   end

`ifdef WB_ARB_TIMEOUT_EN
   logic [15:0] to_cnt_q, to_cnt_d;
   logic        stalled;

   always_comb begin
      stalled  = owned & bus.m_stb[owner_q] & ~bus.s_ack & ~bus.s_err;
      to_fire  = stalled & (to_cnt_q == 16'(TIMEOUT_CYCLES - 1));
      to_cnt_d = (stalled && !to_fire) ? to_cnt_q + 16'd1 : 16'd0;
   end

   always_ff @(posedge clk) begin
      if (rst) to_cnt_q <= '0;
      else     to_cnt_q <= to_cnt_d;
   end
`else
   assign to_fire = 1'b0;
`endif

   // Slave-side fields follow the owner combinationally; controls are masked when idle,
   // in reset, or on the cycle the watchdog aborts the access.
   always_comb begin
      bus.s_adr   = bus.m_adr[owner_q];
      bus.s_dat_w = bus.m_dat_w[owner_q];
      bus.s_sel   = bus.m_sel[owner_q];
      bus.s_cti   = bus.m_cti[owner_q];
      bus.s_bte   = bus.m_bte[owner_q];
      bus.s_cyc   = owned & bus.m_cyc[owner_q] & ~to_fire & ~rst;
      bus.s_stb   = owned & bus.m_stb[owner_q] & ~to_fire & ~rst;
      bus.s_we    = owned & bus.m_we[owner_q];
      bus.m_dat_r = {NUM_MASTERS{bus.s_dat_r}};
      bus.m_ack   = '0;
      bus.m_err   = '0;
      if (owned && !rst) begin
         bus.m_ack[owner_q] = bus.s_ack;
         bus.m_err[owner_q] = bus.s_err | to_fire;
      end
      bus.grant = grant_q;
   end
endmodule

// File: tb/tb_wishbone_rr_arbiter.sv
// Scoreboard bench for wishbone_rr_arbiter: stimulus queues expected grants/responses,
// a negedge monitor pops and compares whenever the DUT grants or responds.
module tb_wishbone_rr_arbiter;
   localparam int NM = 4;
   localparam int AW = 30;
   localparam int DW = 32;
   localparam int TO = 16;

   typedef struct {
      logic [NM-1:0] ack;
      logic [NM-1:0] err;
      logic [DW-1:0] dat;
      bit            chk_dat;
   } resp_t;

   logic clk = 1'b0;
   logic rst;
   logic stall;
   logic [AW-1:0] err_adr;

   int checks = 0;
   int errors = 0;

   logic [NM-1:0] exp_grant_q[$];
   resp_t         exp_resp_q[$];

   wishbone_rr_arbiter_if #(.NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW)) bus();

   wishbone_rr_arbiter #(
      .NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] rdat(input logic [AW-1:0] a);
      return {2'b00, a} ^ 32'hC0DE_0000;
   endfunction

   function automatic logic [AW-1:0] badr(input int k, input int b);
      return AW'(k * 256 + b);
   endfunction

   // Registered slave: one ack/err per stb, never on back-to-back cycles.
   always @(posedge clk) begin
      if (rst) begin
         bus.s_ack <= 1'b0;
         bus.s_err <= 1'b0;
      end else if (bus.s_cyc && bus.s_stb && !bus.s_ack && !bus.s_err && !stall) begin
         if (bus.s_adr == err_adr) bus.s_err <= 1'b1;
         else begin
            bus.s_ack   <= 1'b1;
            bus.s_dat_r <= rdat(bus.s_adr);
         end
      end else begin
         bus.s_ack <= 1'b0;
         bus.s_err <= 1'b0;
      end
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic push_grant(input int k);
      exp_grant_q.push_back(NM'(1) << k);
   endtask

   task automatic push_resp(input int k, input bit is_err, input logic [AW-1:0] a);
      resp_t r;
      r.ack     = is_err ? '0 : NM'(1) << k;
      r.err     = is_err ? NM'(1) << k : '0;
      r.dat     = rdat(a);
      r.chk_dat = !is_err;
      exp_resp_q.push_back(r);
   endtask

   // Monitor: every new grant and every response cycle is matched against the queues.
   logic [NM-1:0] prev_grant = '0;
   initial forever begin
      @(negedge clk);
      if (bus.grant != prev_grant && bus.grant != '0) begin
         chk("idle_gap_before_grant", 128'(prev_grant), 128'(0));
         if (exp_grant_q.size() == 0) chk("unexpected_grant", 128'(bus.grant), 128'(0));
         else chk("grant", 128'(bus.grant), 128'(exp_grant_q.pop_front()));
      end
      prev_grant = bus.grant;
      if (|bus.m_ack || |bus.m_err) begin
         if (exp_resp_q.size() == 0) begin
            chk("unexpected_ack", 128'(bus.m_ack), 128'(0));
            chk("unexpected_err", 128'(bus.m_err), 128'(0));
         end else begin
            resp_t r;
            r = exp_resp_q.pop_front();
            chk("resp_ack", 128'(bus.m_ack), 128'(r.ack));
            chk("resp_err", 128'(bus.m_err), 128'(r.err));
            if (r.chk_dat) chk("resp_dat", 128'(bus.m_dat_r), 128'({NM{r.dat}}));
         end
      end
   end

   task automatic wait_resp(input int k, output bit got, output bit was_err);
      got = 0;
      was_err = 0;
      for (int n = 0; n < 200 && !got; n++) begin
         @(negedge clk);
         if (bus.m_ack[k] || bus.m_err[k]) begin
            got = 1;
            was_err = bus.m_err[k];
         end
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL resp_timeout master=%0d actual=none required=ack_or_err", k);
      end
   endtask

   // One cyc span of nbeats; ends early on err. Leaves cyc low for at least one cycle.
   task automatic master_xfer(input int k, input int nbeats, input logic [2:0] cti);
      bit got, was_err;
      bus.m_cyc[k]   = 1'b1;
      bus.m_stb[k]   = 1'b1;
      bus.m_we[k]    = k[0];
      bus.m_sel[k]   = 4'hF;
      bus.m_cti[k]   = cti;
      bus.m_bte[k]   = 2'b00;
      for (int b = 0; b < nbeats; b++) begin
         bus.m_adr[k]   = badr(k, b);
         bus.m_dat_w[k] = DW'(k * 16 + b);
         wait_resp(k, got, was_err);
         if (got) begin
            chk("pass_adr", 128'(bus.s_adr), 128'(badr(k, b)));
            chk("pass_cti", 128'(bus.s_cti), 128'(cti));
         end
         @(posedge clk); #1;
         if (was_err || !got) break;
      end
      bus.m_cyc[k] = 1'b0;
      bus.m_stb[k] = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      bit got, was_err, saw;
      int d;
      rst         = 1'b1;
      stall       = 1'b0;
      err_adr     = '1;
      bus.m_adr   = '0;
      bus.m_dat_w = '0;
      bus.m_sel   = '0;
      bus.m_we    = '0;
      bus.m_cti   = '0;
      bus.m_bte   = '0;
      bus.m_cyc   = '1;
      bus.m_stb   = '1;
      bus.s_dat_r = '0;

      // Reset with every master requesting: nothing may leak out.
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_grant", 128'(bus.grant), 128'(0));
      chk("reset_s_cyc", 128'(bus.s_cyc), 128'(0));
      chk("reset_s_stb", 128'(bus.s_stb), 128'(0));
      chk("reset_m_ack", 128'(bus.m_ack), 128'(0));
      chk("reset_m_err", 128'(bus.m_err), 128'(0));
      @(posedge clk); #1;
      bus.m_cyc = '0;
      bus.m_stb = '0;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("idle_s_cyc", 128'(bus.s_cyc), 128'(0));

      // Two masters contending: strict alternation 0,1,0,1...
      for (int i = 0; i < 4; i++) begin
         push_grant(0); push_resp(0, 0, badr(0, 0));
         push_grant(1); push_resp(1, 0, badr(1, 0));
      end
      fork
         repeat (4) master_xfer(0, 1, 3'b000);
         repeat (4) master_xfer(1, 1, 3'b000);
      join

      // Lone master 2, 8-beat incrementing burst keeps ownership throughout.
      push_grant(2);
      for (int b = 0; b < 8; b++) push_resp(2, 0, badr(2, b));
      master_xfer(2, 8, 3'b010);

      // rr_ptr now 3: simultaneous requests from 0,1,3 are served 3,0,1.
      push_grant(3); push_resp(3, 0, badr(3, 0));
      push_grant(0); push_resp(0, 0, badr(0, 0));
      push_grant(1); push_resp(1, 0, badr(1, 0));
      fork
         master_xfer(0, 1, 3'b000);
         master_xfer(1, 1, 3'b000);
         master_xfer(3, 1, 3'b000);
      join

      // Slave error on the second beat of master 1 goes to master 1 only, one cycle.
      err_adr = badr(1, 1);
      push_grant(1);
      push_resp(1, 0, badr(1, 0));
      push_resp(1, 1, badr(1, 1));
      master_xfer(1, 3, 3'b010);
      err_adr = '1;

      // Reset mid-burst on master 0, landing on a cycle where the slave acks.
      push_grant(0);
      push_resp(0, 0, badr(0, 0));
      push_resp(0, 0, badr(0, 1));
      bus.m_cyc[0] = 1'b1;
      bus.m_stb[0] = 1'b1;
      bus.m_cti[0] = 3'b010;
      bus.m_adr[0] = badr(0, 0);
      wait_resp(0, got, was_err);
      @(posedge clk); #1;
      bus.m_adr[0] = badr(0, 1);
      wait_resp(0, got, was_err);
      @(posedge clk); #1;
      bus.m_adr[0] = badr(0, 2);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mask_m_ack", 128'(bus.m_ack), 128'(0));
      chk("rst_mask_s_cyc", 128'(bus.s_cyc), 128'(0));
      chk("rst_mask_s_stb", 128'(bus.s_stb), 128'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      bus.m_cyc = '0;
      bus.m_stb = '0;
      @(negedge clk);
      chk("post_rst_grant", 128'(bus.grant), 128'(0));
      chk("post_rst_s_cyc", 128'(bus.s_cyc), 128'(0));
      push_grant(0); push_resp(0, 0, badr(0, 0));
      push_grant(3); push_resp(3, 0, badr(3, 0));
      fork
         master_xfer(0, 1, 3'b000);
         master_xfer(3, 1, 3'b000);
         begin
            @(posedge clk);
            @(negedge clk);
            chk("grant_latency", 128'(bus.grant), 128'(1));
         end
      join

      // Stalled slave.
      stall = 1'b1;
      push_grant(0);
      bus.m_cyc[0] = 1'b1;
      bus.m_stb[0] = 1'b1;
      bus.m_adr[0] = badr(0, 5);
`ifdef WB_ARB_TIMEOUT_EN
      push_resp(0, 1, badr(0, 5));
      saw = 0;
      for (int n = 0; n < 20 && !saw; n++) begin
         @(negedge clk);
         saw = bus.s_stb;
      end
      chk("timeout_stb_seen", 128'(saw), 128'(1));
      d = 0;
      saw = 0;
      while (!saw && d < 100) begin
         @(negedge clk);
         d++;
         saw = bus.m_err[0];
      end
      chk("timeout_dist", 128'(d), 128'(TO - 1));
      chk("timeout_s_stb", 128'(bus.s_stb), 128'(0));
      chk("timeout_s_cyc", 128'(bus.s_cyc), 128'(0));
      chk("timeout_grant", 128'(bus.grant), 128'(1));
`else
      saw = 0;
      d = 0;
      repeat (1000) begin
         @(negedge clk);
         if (bus.m_err != '0) saw = 1;
      end
      chk("no_timeout_err", 128'(saw), 128'(0));
      chk("no_timeout_grant", 128'(bus.grant), 128'(1));
`endif
      @(posedge clk); #1;
      bus.m_cyc[0] = 1'b0;
      bus.m_stb[0] = 1'b0;
      stall = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("final_idle", 128'(bus.grant), 128'(0));
      chk("grant_q_drained", 128'(exp_grant_q.size()), 128'(0));
      chk("resp_q_drained", 128'(exp_resp_q.size()), 128'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
